lsu_mem_initiator: RTL
======================

# lsu_mem_initiator

Request-side counterpart of the shared `memory` model: takes one load/store request at a time from the LSU, drives the memory port's lane strobes, and waits for the tagged `ack`. It then returns the captured read data (or completion status) on a valid/ready response port. It sits between the LSU issue logic and the `memory` block, and it owns tag matching, stray-ack accounting and an optional response timeout.

## Interface
- `TAG_W`, 7, width of request/response tag
- `TIMEOUT`, 255, WAIT cycles without matching ack before error completion (only with macro)
- `clk` in 1, single clock, all state on rising edge
- `rst` in 1, asynchronous, active-low reset
- `req_valid` in 1, request present
- `req_ready` out 1, request accepted when `req_valid & req_ready`
- `req_gm_or_lds` in 1, 1 = global memory, 0 = LDS
- `req_rd_en` in 4, per-lane-group read enables
- `req_wr_en` in 4, per-lane-group write enables
- `req_addresses` in 2048, 64 x 32-bit addresses
- `req_wr_data` in 8192, store data
- `req_tag` in TAG_W, transaction tag
- `gm_or_lds` out 1, to memory
- `rd_en` out 4, to memory
- `wr_en` out 4, to memory
- `addresses` out 2048, to memory
- `wr_data` out 8192, to memory
- `input_tag` out TAG_W, to memory
- `rd_data` in 8192, from memory
- `output_tag` in TAG_W, from memory
- `ack` in 1, from memory, qualifies `output_tag`/`rd_data`
- `rsp_valid` out 1, response present
- `rsp_ready` in 1, response consumed when `rsp_valid & rsp_ready`
- `rsp_tag` out TAG_W, tag of completed request
- `rsp_rd_data` out 8192, captured read data (zero for writes/errors)
- `rsp_is_write` out 1, completed transaction was a store
- `rsp_error` out 1, completion by timeout
- `stray_acks` out 8, saturating count of acks with non-matching tag

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On accept, register all request fields and go to ISSUE.
- Classification: `|req_rd_en` → read, and `wr_en` is forced to 0. Otherwise `|req_wr_en` → write. Both zero → null request: skip ISSUE/WAIT, go straight to RESP with `rsp_error`=0, `rsp_is_write`=0, data 0.
- ISSUE: `rd_en`/`wr_en` driven with registered enables for exactly one cycle, then go to WAIT. `gm_or_lds`, `addresses`, `wr_data`, `input_tag` hold the last accepted request's values at all times.
- WAIT: `ack` with `output_tag == input_tag` → capture `rd_data` (read) or zero (write), go to RESP. `ack` with mismatched tag → `stray_acks` +1, saturating at 255, stay in WAIT.
- `ack` is sampled in ISSUE as well as WAIT. A matching ack in the ISSUE cycle completes immediately (ISSUE→RESP).
- RESP: `rsp_valid`=1 with all fields stable until `rsp_ready`. The handshake returns to IDLE. `ack` in RESP or IDLE is ignored and not counted.

## Timing
- Reset values: all outputs 0 except none. `req_ready`=0 during reset, and becomes 1 the first cycle after deassert (state IDLE).
- Accept at edge N → strobes high for cycle N+1 only.
- Matching ack sampled at edge M → `rsp_valid` high from cycle M+1.
- Minimum accept-to-`rsp_valid` latency: 2 cycles (ack in ISSUE cycle). For a null request: 1 cycle.
- Response handshake at edge R → `req_ready` high in cycle R+1. There is no request/response overlap, so throughput is one transaction per 3+ cycles.
- `rst` asserted mid-transaction: immediate return to IDLE, strobes drop asynchronously, `stray_acks` cleared. A late ack after reset is ignored.

## Configuration
- `LSU_MEM_INIT_TIMEOUT_EN` defined: an 8+ bit counter runs in WAIT and clears on entering WAIT. On reaching `TIMEOUT` without a matching ack → RESP with `rsp_error`=1, `rsp_rd_data`=0, and `rsp_tag` = the request tag. A matching ack in the same cycle as expiry wins, with `rsp_error`=0.
- Not defined: no counter. WAIT holds indefinitely, and `rsp_error` is tied 0.

## Test plan
- Write: tag 1, gm=1, addresses {34,24,14,04}, `wr_en`=0101 → `wr_en`=0101 for one cycle. Memory acks with tag 1 → `rsp_valid`, `rsp_tag`=1, `rsp_is_write`=1, `rsp_rd_data`=0.
- Read-back: tag 2, `rd_en`=0101, `wr_en`=1111 → `wr_en` stays 0000, `rd_en`=0101 for one cycle. `rsp_rd_data` matches written words 4/3 at lanes 0/2.
- Stray: in WAIT, inject acks with tag 5 then 9, then tag 2 → `stray_acks`=2, a single response with tag 2.
- Backpressure: hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and fields stable, `req_ready`=0 throughout. Release → `req_ready`=1 next cycle.
- Null/reset: `rd_en`=`wr_en`=0 → `rsp_valid` one cycle after accept, no strobes. Assert `rst` in WAIT → all outputs 0, and a subsequent ack produces no response.
- With `LSU_MEM_INIT_TIMEOUT_EN`, TIMEOUT=8: no ack → `rsp_error`=1 exactly 8 WAIT cycles after ISSUE. Without the macro: no response after 1000 cycles.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - single-outstanding LSU request initiator toward the memory model (optional timeout: LSU_MEM_INIT_TIMEOUT_EN)
module lsu_mem_initiator #(
    parameter int TAG_W = 7
`ifdef LSU_MEM_INIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_gm_or_lds,
    input  logic [3:0]         req_rd_en,
    input  logic [3:0]         req_wr_en,
    input  logic [2047:0]      req_addresses,
    input  logic [8191:0]      req_wr_data,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               gm_or_lds,
    output logic [3:0]         rd_en,
    output logic [3:0]         wr_en,
    output logic [2047:0]      addresses,
    output logic [8191:0]      wr_data,
    output logic [TAG_W-1:0]   input_tag,
    input  logic [8191:0]      rd_data,
    input  logic [TAG_W-1:0]   output_tag,
    input  logic               ack,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [8191:0]      rsp_rd_data,
    output logic               rsp_is_write,
    output logic               rsp_error,
    output logic [7:0]         stray_acks
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] rd_en_q;
    logic [3:0] wr_en_q;
    logic       is_write_q;
    logic       accept;
    logic       sampling;
    logic       ack_match;
    logic       ack_stray;
    logic       timeout_hit;

    // Acks only matter while a request is outstanding on the memory port.
    assign sampling  = (state == ISSUE) || (state == WAIT);
    assign ack_match = sampling && ack && (output_tag == input_tag);
    assign ack_stray = sampling && ack && (output_tag != input_tag);

    // Ready is masked by reset so it reads 0 while reset is held.
    assign req_ready = (state == IDLE) && rst;
    assign accept    = req_valid && req_ready;

    assign rd_en     = (state == ISSUE) ? rd_en_q : 4'b0;
    assign wr_en     = (state == ISSUE) ? wr_en_q : 4'b0;
    assign rsp_valid = (state == RESP);
    assign rsp_tag   = input_tag;

`ifdef LSU_MEM_INIT_TIMEOUT_EN
    logic [15:0] timer;

    // Counts WAIT cycles; held at zero outside WAIT so it starts fresh on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 16'd0;
        end else if (state != WAIT) begin
            timer <= 16'd0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    assign timeout_hit = (state == WAIT) && (timer == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: null requests skip straight to RESP; a matching ack beats expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ((req_rd_en != 4'b0) || (req_wr_en != 4'b0)) ? ISSUE : RESP;
                end
            end
            ISSUE, WAIT: begin
                state_next = (ack_match || timeout_hit) ? RESP : WAIT;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted request; a read suppresses any write enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gm_or_lds  <= 1'b0;
            addresses  <= '0;
            wr_data    <= '0;
            input_tag  <= '0;
            rd_en_q    <= 4'b0;
            wr_en_q    <= 4'b0;
            is_write_q <= 1'b0;
        end else if (accept) begin
            gm_or_lds  <= req_gm_or_lds;
            addresses  <= req_addresses;
            wr_data    <= req_wr_data;
            input_tag  <= req_tag;
            rd_en_q    <= req_rd_en;
            wr_en_q    <= (req_rd_en != 4'b0) ? 4'b0 : req_wr_en;
            is_write_q <= (req_rd_en == 4'b0) && (req_wr_en != 4'b0);
        end
    end

    // Response fields: cleared on accept (covers null requests), filled on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rd_data  <= '0;
            rsp_is_write <= 1'b0;
            rsp_error    <= 1'b0;
        end else if (accept) begin
            rsp_rd_data  <= '0;
            rsp_is_write <= 1'b0;
            rsp_error    <= 1'b0;
        end else if (ack_match || timeout_hit) begin
            rsp_is_write <= is_write_q;
            rsp_error    <= !ack_match;
            rsp_rd_data  <= (ack_match && !is_write_q) ? rd_data : '0;
        end
    end

    // Saturating count of acks whose tag does not match the outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stray_acks <= 8'd0;
        end else if (ack_stray && (stray_acks != 8'hFF)) begin
            stray_acks <= stray_acks + 8'd1;
        end
    end

endmodule
